// File: rtl/fibo_bcd_display_pkg.sv
// Shared types and constants for the Fibonacci BCD display stage.
package fibo_bcd_display_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned DIGITS_DEF  = 5;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] GLYPH_0     = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h00;

  // Non-decimal codes cannot occur from the converter; show them dark.
  function automatic logic [SEG_W-1:0] seg_glyph(input logic [BCD_DIGIT_W-1:0] v);
    logic [SEG_W-1:0] g;
    g = GLYPH_BLANK;
    case (v)
      4'd0: g = GLYPH_0;
      4'd1: g = GLYPH_1;
      4'd2: g = GLYPH_2;
      4'd3: g = GLYPH_3;
      4'd4: g = GLYPH_4;
      4'd5: g = GLYPH_5;
      4'd6: g = GLYPH_6;
      4'd7: g = GLYPH_7;
      4'd8: g = GLYPH_8;
      4'd9: g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fibo_bcd_display_if.sv
// Bundle between the Fibonacci calculator side and the BCD display stage.
interface fibo_bcd_display_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIGITS = 5
) ();

  logic                  start;
  logic [DATA_W-1:0]     bin_in;
  logic                  busy;
  logic                  conv_done;
  logic                  bcd_valid;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output start, bin_in,
    input  busy, conv_done, bcd_valid, bcd_out, seg_out
  );

  modport slave (
    input  start, bin_in,
    output busy, conv_done, bcd_valid, bcd_out, seg_out
  );

endinterface

// File: rtl/fibo_bcd_display_seven_seg_decoder.sv
// One BCD digit to a 7-segment pattern with blanking and selectable polarity.
module seven_seg_decoder
  import fibo_bcd_display_pkg::*;
#(
  parameter bit ACT_LO = 1'b1
) (
  input  logic [BCD_DIGIT_W-1:0] bcd,
  input  logic                   blank,
  output logic [SEG_W-1:0]       seg_c
);

  logic [SEG_W-1:0] lit;

  always_comb begin
    lit   = blank ? GLYPH_BLANK : seg_glyph(bcd);
    seg_c = ACT_LO ? ~lit : lit;
  end

endmodule

// File: rtl/fibo_bcd_display.sv
// Captures a binary result on a start rising edge, converts it to BCD with a
// sequential double-dabble engine and drives one 7-segment pattern per digit.
module fibo_bcd_display
  import fibo_bcd_display_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DIGITS     = DIGITS_DEF,
  parameter bit          SEG_ACT_LO = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  fibo_bcd_display_if.slave  bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  conv_state_e        state_q, state_d;
  logic               start_q, start_d;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               busy_q, busy_d;
  logic               conv_done_q, conv_done_d;
  logic               bcd_valid_q, bcd_valid_d;

  logic               accept_c;
  logic [BCD_W-1:0]   adj_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_out_q   <= '0;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bcd_out_q   <= bcd_out_d;
      busy_q      <= busy_d;
      conv_done_q <= conv_done_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  // Per-digit add-3 correction ahead of each shift; 4-bit, no inter-digit carry.
  always_comb begin
    adj_c = acc_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj_c[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
  end

  assign start_d  = bus.start;
  assign accept_c = bus.start & ~start_q & (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_out_d   = bcd_out_q;
    busy_d      = busy_q;
    conv_done_d = 1'b0;
    bcd_valid_d = bcd_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SHIFT;
          bin_d   = bus.bin_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        acc_d = BCD_W'({adj_c, bin_q[DATA_W-1]});
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        // The last iteration publishes the result in the same edge.
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          bcd_out_d   = acc_d;
          conv_done_d = 1'b1;
          bcd_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.conv_done = conv_done_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.bcd_out   = bcd_out_q;

  logic [SEG_W*DIGITS-1:0] seg_c;

  // Digit k is blank when it and every higher digit are zero; digit 0 always shows.
  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_dig
    logic blank_c;
    if (k == 0) begin : g_first
      assign blank_c = 1'b0;
    end else begin : g_upper
      assign blank_c = BLANK_LZ && (bcd_out_q[BCD_W-1:4*k] == '0);
    end
    seven_seg_decoder #(.ACT_LO(SEG_ACT_LO)) u_dec (
      .bcd   (bcd_out_q[4*k +: 4]),
      .blank (blank_c),
      .seg_c (seg_c[SEG_W*k +: SEG_W])
    );
  end

  assign bus.seg_out = seg_c;

endmodule
